// File: rtl/mux2_rr_arbiter.sv
// rtl/mux2_rr_arbiter.sv - round-robin 2:1 source arbiter feeding a registered word plus its select (optional counters: MUX2_ARB_CNT_EN)
module mux2_rr_arbiter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] a_data,
  input  logic         a_valid,
  output logic         a_ready,
  input  logic [W-1:0] b_data,
  input  logic         b_valid,
  output logic         b_ready,
  output logic [W-1:0] y_data,
  output logic         y_sel,
  output logic         y_valid,
  input  logic         y_ready
`ifdef MUX2_ARB_CNT_EN
  ,
  output logic [15:0]  cnt_a,
  output logic [15:0]  cnt_b
`endif
);

  logic [W-1:0] y_data_q, y_data_d;
  logic         y_sel_q, y_sel_d;
  logic         y_valid_q, y_valid_d;
  // 0 = A won last transfer, 1 = B; reset to B so A takes the first tie
  logic         last_grant_q, last_grant_d;

  logic load_en;
  logic grant_a, grant_b;
  logic a_xfer, b_xfer;

  // Grant and handshake: the slice may load when empty or draining; priority only breaks ties
  always_comb begin
    load_en = !y_valid_q || y_ready;
    grant_a = a_valid && (!b_valid || last_grant_q);
    grant_b = b_valid && (!a_valid || !last_grant_q);
    a_ready = !reset && load_en && grant_a;
    b_ready = !reset && load_en && grant_b;
    a_xfer  = a_valid && a_ready;
    b_xfer  = b_valid && b_ready;
  end

  // Next state of the output slice: a new word overwrites a draining one with no bubble
  always_comb begin
    y_data_d     = y_data_q;
    y_sel_d      = y_sel_q;
    y_valid_d    = y_valid_q;
    last_grant_d = last_grant_q;
    if (a_xfer) begin
      y_data_d     = a_data;
      y_sel_d      = 1'b0;
      y_valid_d    = 1'b1;
      last_grant_d = 1'b0;
    end else if (b_xfer) begin
      y_data_d     = b_data;
      y_sel_d      = 1'b1;
      y_valid_d    = 1'b1;
      last_grant_d = 1'b1;
    end else if (y_valid_q && y_ready) begin
      y_valid_d = 1'b0;
    end
  end

  // Output slice and priority state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      y_data_q     <= '0;
      y_sel_q      <= 1'b0;
      y_valid_q    <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      y_data_q     <= y_data_d;
      y_sel_q      <= y_sel_d;
      y_valid_q    <= y_valid_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign y_data  = y_data_q;
  assign y_sel   = y_sel_q;
  assign y_valid = y_valid_q;

`ifdef MUX2_ARB_CNT_EN
  logic [15:0] cnt_a_q, cnt_a_d;
  logic [15:0] cnt_b_q, cnt_b_d;

  // Saturating per-channel transfer counters
  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    if (a_xfer && cnt_a_q != 16'hFFFF) cnt_a_d = cnt_a_q + 16'd1;
    if (b_xfer && cnt_b_q != 16'hFFFF) cnt_b_d = cnt_b_q + 16'd1;
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_a_q <= 16'd0;
      cnt_b_q <= 16'd0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  assign cnt_a = cnt_a_q;
  assign cnt_b = cnt_b_q;
`endif

endmodule
